// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default clock/baud
// constants (also used by the TX side) and the bit-counter width helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BRK    = 3'd5
  } uart_state_t;

  localparam int DEF_CLK_FREQ     = 100000000;
  localparam int DEF_BAUD         = 1000000;
  localparam int DEF_CLKS_PER_BIT = DEF_CLK_FREQ / DEF_BAUD;

  function automatic int cnt_width(input int clks_per_bit);
    return $clog2(clks_per_bit);
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_CLKS_PER_BIT);

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous bit; RST_VAL sets the
// value both flops take on reset (1 for an idle-high serial line).
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_inst.sv
// UART receiver (8N1) producing calculator instruction bytes with a one-cycle
// inst_vld strobe. Define UART_RX_PARITY_EN for 8E1 with even-parity checking.
module uart_rx_inst
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = DEF_CLK_FREQ,
  parameter int BAUD         = DEF_BAUD,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] inst_wd,
  output logic       inst_vld,
  output logic       frm_err,
  output logic       busy
);

  if (CLKS_PER_BIT < 4) begin : g_bad_cpb
    $error("uart_rx_inst: CLKS_PER_BIT must be at least 4");
  end

  localparam int CNT_W = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  uart_state_t      r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic [2:0]       r_idx, w_idx_nx;
  logic [7:0]       r_shift, w_shift_nx;
  logic [7:0]       r_wd, w_wd_nx;
  logic             r_vld, w_vld_nx;
  logic             r_err, w_err_nx;
  logic             w_rx_s;
  logic             w_frame_bad;

  sync2 #(.RST_VAL(1'b1)) u_sync (
    .i_clk (clk),
    .i_rst (rst),
    .i_d   (rx),
    .o_q   (w_rx_s)
  );

`ifdef UART_RX_PARITY_EN
  logic r_perr, w_perr_nx;

  always_ff @(posedge clk) begin
    if (rst) r_perr <= 1'b0;
    else     r_perr <= w_perr_nx;
  end

  assign w_frame_bad = r_perr;
`else
  assign w_frame_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_wd    <= 8'h00;
      r_vld   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_idx   <= w_idx_nx;
      r_shift <= w_shift_nx;
      r_wd    <= w_wd_nx;
      r_vld   <= w_vld_nx;
      r_err   <= w_err_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_idx_nx   = r_idx;
    w_shift_nx = r_shift;
    w_wd_nx    = r_wd;
    w_vld_nx   = 1'b0;
    w_err_nx   = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_perr_nx  = r_perr;
`endif
    case (r_state)
      IDLE: begin
        if (!w_rx_s) begin
          w_state_nx = START;
          w_cnt_nx   = '0;
        end
      end
      START: begin
        // Half-bit wait re-centres every later sample on mid-bit.
        if (r_cnt == CNT_HALF) begin
          w_cnt_nx = '0;
          w_idx_nx = '0;
          w_state_nx = w_rx_s ? IDLE : DATA;
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nx   = '0;
          w_shift_nx = {w_rx_s, r_shift[7:1]};
          if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state_nx = PARITY;
`else
            w_state_nx = STOP;
`endif
          end else begin
            w_idx_nx = r_idx + 3'd1;
          end
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nx   = '0;
          w_perr_nx  = ^{r_shift, w_rx_s};
          w_state_nx = STOP;
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
`endif
      STOP: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nx = '0;
          if (!w_rx_s) begin
            w_err_nx   = 1'b1;
            w_state_nx = BRK;
          end else if (w_frame_bad) begin
            w_err_nx   = 1'b1;
            w_state_nx = IDLE;
          end else begin
            w_vld_nx   = 1'b1;
            w_wd_nx    = r_shift;
            w_state_nx = IDLE;
          end
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
      BRK: begin
        if (w_rx_s) w_state_nx = IDLE;
      end
      default: begin
        w_state_nx = IDLE;
        w_cnt_nx   = '0;
      end
    endcase
  end

  assign inst_wd  = r_wd;
  assign inst_vld = r_vld;
  assign frm_err  = r_err;
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_inst.sv
// Directed bench for uart_rx_inst at 100 MHz / 1 Mbaud; follows the
// UART_RX_PARITY_EN build of the DUT when that macro is defined.
module tb_uart_rx_inst;

  localparam int CPB = 100;
`ifdef UART_RX_PARITY_EN
  localparam int LAT_MAX = 954 + CPB;
`else
  localparam int LAT_MAX = 954;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] inst_wd;
  logic       inst_vld;
  logic       frm_err;
  logic       busy;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int vld_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int last_vld_cyc = 0;
  logic [7:0] wq[$];

  uart_rx_inst #(.CLK_FREQ(100000000), .BAUD(1000000)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .inst_wd  (inst_wd),
    .inst_vld (inst_vld),
    .frm_err  (frm_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (inst_vld) begin
      vld_cnt++;
      last_vld_cyc = cyc;
      wq.push_back(inst_wd);
    end
    if (frm_err) err_cnt++;
    if (inst_vld && frm_err) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bit_out(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_b, input logic par_flip);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i]);
`ifdef UART_RX_PARITY_EN
    bit_out((^d) ^ par_flip);
`endif
    bit_out(stop_b);
  endtask

  task automatic chk_next(input string tag, input logic [7:0] exp);
    logic [31:0] got;
    if (wq.size() > 0) got = {24'h0, wq.pop_front()};
    else               got = 32'hDEAD_BEEF;
    chk(tag, got, {24'h0, exp});
  endtask

  initial begin
    int v0, e0, c0;
    logic [7:0] b2b [4];
    b2b[0] = 8'h34; b2b[1] = 8'h00; b2b[2] = 8'h13; b2b[3] = 8'h86;

    // Reset, then a long idle stretch
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("rst_wd", {24'h0, inst_wd}, 32'h00);
    chk("rst_vld", {31'h0, inst_vld}, 32'h0);
    chk("rst_err", {31'h0, frm_err}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    @(posedge clk);
    rst = 1'b0;
    repeat (2000) @(posedge clk);
    chk("idle_vld", vld_cnt, 0);
    chk("idle_err", err_cnt, 0);

    // Single frame with latency bound
    v0 = vld_cnt; c0 = cyc;
    send_byte(8'h34, 1'b1, 1'b0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("single_cnt", vld_cnt - v0, 1);
    chk_next("single_wd", 8'h34);
    chk("single_lat", {31'h0, (last_vld_cyc - c0) <= LAT_MAX}, 32'h1);
    chk("single_busy", {31'h0, busy}, 32'h0);

    // Four frames with no idle bits between them
    v0 = vld_cnt;
    for (int i = 0; i < 4; i++) send_byte(b2b[i], 1'b1, 1'b0);
    repeat (20) @(posedge clk);
    chk("b2b_cnt", vld_cnt - v0, 4);
    for (int i = 0; i < 4; i++) chk_next($sformatf("b2b_wd%0d", i), b2b[i]);

    // Short low glitch must not start a frame
    v0 = vld_cnt; e0 = err_cnt;
    rx = 1'b0;
    repeat (30) @(posedge clk);
    rx = 1'b1;
    repeat (25) @(posedge clk);
    @(negedge clk);
    chk("glitch_busy", {31'h0, busy}, 32'h0);
    chk("glitch_vld", vld_cnt - v0, 0);
    chk("glitch_err", err_cnt - e0, 0);

    // Bad stop bit followed by a held-low line
    v0 = vld_cnt; e0 = err_cnt;
    send_byte(8'hC0, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (500) @(posedge clk);
    @(negedge clk);
    chk("ferr_err", err_cnt - e0, 1);
    chk("ferr_vld", vld_cnt - v0, 0);
    chk("ferr_wd", {24'h0, inst_wd}, 32'h86);
    chk("ferr_busy", {31'h0, busy}, 32'h1);
    rx = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    chk("brk_exit", {31'h0, busy}, 32'h0);
    send_byte(8'hC0, 1'b1, 1'b0);
    repeat (20) @(posedge clk);
    chk("ferr_recov_cnt", vld_cnt - v0, 1);
    chk_next("ferr_recov_wd", 8'hC0);
    chk("ferr_recov_err", err_cnt - e0, 1);

    // Reset during data bit 4
    v0 = vld_cnt; e0 = err_cnt;
    bit_out(1'b0);
    for (int i = 0; i < 4; i++) bit_out(b2b[0][i] ^ 1'b1);
    rx = 1'b1;
    repeat (50) @(posedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mrst_wd", {24'h0, inst_wd}, 32'h00);
    chk("mrst_vld", {31'h0, inst_vld}, 32'h0);
    chk("mrst_err", {31'h0, frm_err}, 32'h0);
    chk("mrst_busy", {31'h0, busy}, 32'h0);
    @(posedge clk);
    rst = 1'b0;
    repeat (2 * CPB) @(posedge clk);
    chk("mrst_nopulse", vld_cnt - v0, 0);
    send_byte(8'h5A, 1'b1, 1'b0);
    repeat (20) @(posedge clk);
    chk("mrst_next_cnt", vld_cnt - v0, 1);
    chk_next("mrst_next_wd", 8'h5A);

`ifdef UART_RX_PARITY_EN
    // Even parity: 8'h5A has four ones, so parity bit 0 is good
    v0 = vld_cnt; e0 = err_cnt;
    rx = 1'b1; repeat (CPB) @(posedge clk);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b2b[0][i] ^ b2b[0][i] ^ ((8'h5A >> i) & 1'b1));
    bit_out(1'b0);
    bit_out(1'b1);
    repeat (20) @(posedge clk);
    chk("par_good_vld", vld_cnt - v0, 1);
    chk_next("par_good_wd", 8'h5A);
    v0 = vld_cnt;
    send_byte(8'h5A, 1'b1, 1'b1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("par_bad_vld", vld_cnt - v0, 0);
    chk("par_bad_err", err_cnt - e0, 1);
    chk("par_bad_busy", {31'h0, busy}, 32'h0);
`endif

    chk("vld_err_excl", both_cnt, 0);
    chk("queue_empty", wq.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_rx_inst.md
Name: uart_rx_inst

Overview:
- UART receiver that turns serial bytes on the board RX pin (RsRx) into instruction words for the calculator sequencer.
- Alternate instruction source to the sw/btnS path: each good byte gives inst_wd plus a one-cycle inst_vld, the same contract the sequencer already consumes.
- Pairs with the existing UART transmitter (RsTx) and the bench model_uart (baud 1000000).

Parameters:
- CLK_FREQ, 100000000, system clock in Hz.
- BAUD, 1000000, serial bit rate.
- CLKS_PER_BIT, CLK_FREQ/BAUD (100), clocks per bit. Must be at least 4; smaller is an elaboration error.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- rx  in  1  asynchronous serial input, idle high.
- inst_wd  out  8  last received byte; held between frames.
- inst_vld  out  1  one-cycle pulse; inst_wd is valid in the same cycle.
- frm_err  out  1  one-cycle pulse on a bad stop bit (or bad parity).
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset values: inst_wd=8'h00, inst_vld=0, frm_err=0, busy=0, state=IDLE, both sync flops=1, counters=0.
- Reset asserted mid-frame aborts the frame immediately; no inst_vld is produced.
- Synchronizer: rx passes through 2 flops (rx_s). All decisions use rx_s only.
- Bit counter cnt runs 0..CLKS_PER_BIT-1. Bit index idx runs 0..7.
- States: IDLE, START, DATA, (PARITY), STOP, BRK.
- IDLE:
  - rx_s==0 -> START, cnt=0.
- START:
  - At cnt==CLKS_PER_BIT/2-1, sample rx_s.
  - Sample 1 (glitch) -> IDLE, no pulse.
  - Sample 0 -> DATA, cnt=0, idx=0.
- DATA:
  - At cnt==CLKS_PER_BIT-1, shift rx_s into the shift register LSB first and set cnt=0.
  - After idx==7 -> STOP (or PARITY when the optional feature is on).
- STOP:
  - At cnt==CLKS_PER_BIT-1, sample rx_s.
  - Sample 1: next cycle inst_wd<=shift register and inst_vld=1 for exactly one cycle; -> IDLE.
  - Sample 0: frm_err=1 for one cycle, inst_wd unchanged; -> BRK.
- BRK:
  - Stay until rx_s==1, then IDLE. A held-low line produces exactly one frm_err.
- Latency: inst_vld rises at most 2 (sync) + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 2 cycles after the rx falling edge. For the defaults that is ≤ 954 cycles.
- Sampling points sit mid-bit.
- Back-to-back frames: a start edge seen in the cycle after the STOP sample is accepted, so zero idle bits between frames must work.
- inst_vld and frm_err are mutually exclusive and never assert in the same cycle.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - A PARITY state follows DATA and samples one extra bit at cnt==CLKS_PER_BIT-1.
  - Even parity: the XOR of the 8 data bits and the parity bit must be 0.
  - On mismatch, the STOP sample is still taken, then frm_err pulses and inst_vld is suppressed.
  - A parity error with a good stop bit goes to IDLE, not BRK.
  - Latency grows by CLKS_PER_BIT.
- When undefined:
  - No PARITY state and no extra logic; 8N1 only.

Decomposition:
- Shared package uart_pkg:
  - State encoding enum (IDLE, START, DATA, PARITY, STOP, BRK).
  - Default CLK_FREQ/BAUD constants, also reused by the TX side.
  - Width constant for cnt: $clog2(CLKS_PER_BIT).
- One natural sub-module, sync2: a 2-flop synchronizer with a reset value parameter. Everything else stays in uart_rx_inst.

Test Plan:
- Reset then idle: hold rst=1 for 10 cycles with rx=1 -> all outputs 0, busy=0; hold 2000 cycles idle -> no pulses.
- Single frame: send 8'b00110100 (PUSH R0,4) at 1 Mbaud -> exactly one inst_vld with inst_wd=8'h34, within 954 cycles of the start edge; busy then returns low.
- Four back-to-back frames 8'h34, 8'h00, 8'h13, 8'h86 with no idle gap -> four inst_vld pulses, in order, with matching inst_wd.
- Glitch: drive rx low for 30 cycles then high -> START aborts, no inst_vld, no frm_err, busy low again within 55 cycles.
- Framing error: send 8'hC0 with stop bit=0, then hold rx low 500 cycles -> one frm_err, no inst_vld, inst_wd keeps its prior value. Release rx and send 8'hC0 correctly -> inst_vld with 8'hC0.
- Reset mid-frame, and parity with UART_RX_PARITY_EN:
  - Assert rst during bit 4 -> no pulse, outputs at reset values. The next clean frame 8'h5A is received correctly.
  - With the macro defined: 8'h5A with parity 0 -> inst_vld. 8'h5A with parity 1 -> frm_err only.
